// File: rtl/pg_prep_stage_if.sv
// Operand-in / G-P-out bundle for pg_prep_stage; slave is the stage, master its environment.
// PG_PREP_SUB_EN adds the per-beat subtract select.
interface pg_prep_stage_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PG_PREP_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             g_in;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_valid, a, b, cin,
`ifdef PG_PREP_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, g, p, g_in, op_count
    );

    modport master (
        output in_valid, a, b, cin,
`ifdef PG_PREP_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, g, p, g_in, op_count
    );
endinterface

// File: rtl/pg_prep_stage.sv
// Per-bit generate/propagate prep for the prefix carry tree; optional A-B mode under PG_PREP_SUB_EN.
// Latency: 1 cycle from accept to out_valid when empty; full throughput.
// Backpressure: 2-entry skid (main + skid); in_ready is a register, no comb path from out_ready.
module pg_prep_stage #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    pg_prep_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             g_in;
    } gp_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t           state_q, state_d;
    gp_t              main_q, skid_q, beat;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] b_eff;
    logic             in_fire, out_fire;
    logic             load_main_new, load_main_skid, load_skid;

    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = (state_q != EMPTY) & bus.out_ready;

    // Subtract feeds ~b with a forced carry-in so the tree produces A - B.
`ifdef PG_PREP_SUB_EN
    always_comb begin
        b_eff     = bus.sub ? ~bus.b : bus.b;
        beat.g    = bus.a & b_eff;
        beat.p    = bus.a ^ b_eff;
        beat.g_in = bus.sub | bus.cin;
    end
`else
    always_comb begin
        b_eff     = bus.b;
        beat.g    = bus.a & b_eff;
        beat.p    = bus.a ^ b_eff;
        beat.g_in = bus.cin;
    end
`endif

    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    load_main_new = 1'b1;
                    state_d       = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_new = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            // Skid occupancy next cycle decides readiness, keeping in_ready registered.
            in_ready_q <= (state_d != TWO);
            if (load_main_new) begin
                main_q <= beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= beat;
            end
            if (in_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.g         = main_q.g;
    assign bus.p         = main_q.p;
    assign bus.g_in      = main_q.g_in;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_pg_prep_stage.sv
// Directed bench for pg_prep_stage: reset, basic beat, backpressure, streaming, counter wrap,
// reset while full, and the subtract mode when PG_PREP_SUB_EN is defined.
module tb_pg_prep_stage;
    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    pg_prep_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    pg_prep_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic c);
        bus.in_valid = vld;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = c;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic stream(input int n);
        logic [WIDTH-1:0] av, bv;
        logic             c;
        for (int i = 0; i < n; i++) begin
            av = WIDTH'($urandom);
            bv = WIDTH'($urandom);
            c  = 1'($urandom);
            drive(1'b1, av, bv, c);
            tick();
            check("stream_vld", 32'(bus.out_valid), 32'd1);
            check("stream_g", 32'(bus.g), 32'(av & bv));
            check("stream_p", 32'(bus.p), 32'(av ^ bv));
            check("stream_gin", 32'(bus.g_in), 32'(c));
        end
        drive(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PG_PREP_SUB_EN
        bus.sub = 1'b0;
`endif
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);

        // Reset held two cycles with a beat offered.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'd1);
            check("rst_op_count", 32'(bus.op_count), 32'd0);
            check("rst_g", 32'(bus.g), 32'd0);
            check("rst_p", 32'(bus.p), 32'd0);
            check("rst_g_in", 32'(bus.g_in), 32'd0);
        end
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        tick();
        check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        check("idle_op_count", 32'(bus.op_count), 32'd0);

        // Basic beat.
        drive(1'b1, 16'h00FF, 16'h0F0F, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("basic_vld", 32'(bus.out_valid), 32'd1);
        check("basic_g", 32'(bus.g), 32'h000F);
        check("basic_p", 32'(bus.p), 32'h0FF0);
        check("basic_gin", 32'(bus.g_in), 32'd1);
        check("basic_cnt", 32'(bus.op_count), 32'd1);
        tick();
        check("basic_drain", 32'(bus.out_valid), 32'd0);

        // Backpressure: two accepted, third held off until release.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h0000, 1'b0);
        tick();
        check("bp_rdy1", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 16'h0002, 16'h0000, 1'b0);
        tick();
        check("bp_rdy2", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 16'h0003, 16'h0000, 1'b0);
        tick();
        check("bp_rdy3", 32'(bus.in_ready), 32'd0);
        check("bp_cnt_hold", 32'(bus.op_count), 32'd3);
        check("bp_stable_vld", 32'(bus.out_valid), 32'd1);
        check("bp_stable_p", 32'(bus.p), 32'h0001);
        bus.out_ready = 1'b1;
        tick();
        check("bp_out2_p", 32'(bus.p), 32'h0002);
        check("bp_out2_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("bp_out3_vld", 32'(bus.out_valid), 32'd1);
        check("bp_out3_p", 32'(bus.p), 32'h0003);
        check("bp_cnt", 32'(bus.op_count), 32'd4);
        tick();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // Streaming 100 beats at full rate.
        pulse_reset();
        stream(100);
        check("stream_cnt", 32'(bus.op_count), 32'd100);
        tick();
        check("stream_drain", 32'(bus.out_valid), 32'd0);

        // Counter wrap.
        pulse_reset();
        stream(257);
        check("wrap_cnt", 32'(bus.op_count), 32'd1);
        tick();

        // Reset while both entries are full.
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1);
        tick();
        drive(1'b1, 16'h5678, 16'h8765, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("two_rdy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check("two_rst_vld", 32'(bus.out_valid), 32'd0);
        check("two_rst_rdy", 32'(bus.in_ready), 32'd1);
        check("two_rst_cnt", 32'(bus.op_count), 32'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("two_no_stale", 32'(bus.out_valid), 32'd0);
        end

`ifdef PG_PREP_SUB_EN
        // 5 - 3: b_eff = 0xFFFC, g = 0x0004, p = 0xFFF9, forced carry-in.
        bus.sub = 1'b1;
        drive(1'b1, 16'h0005, 16'h0003, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        bus.sub = 1'b0;
        check("sub_g", 32'(bus.g), 32'h0004);
        check("sub_p", 32'(bus.p), 32'hFFF9);
        check("sub_gin", 32'(bus.g_in), 32'd1);
        tick();
        drive(1'b1, 16'h0005, 16'h0003, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0);
        check("add_g", 32'(bus.g), 32'h0001);
        check("add_p", 32'(bus.p), 32'h0006);
        check("add_gin", 32'(bus.g_in), 32'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
